uio_bus_arbiter: RTL and testbench
==================================

# uio_bus_arbiter

Round-robin arbiter that shares the 8-bit bidirectional `uio` pin bank of a Tiny Tapeout user module between up to four internal requesters, such as the core result stream and a debug/readout port. It grants one requester at a time for a length-tagged burst. It inserts a bus-turnaround gap before driving, and owns `uio_out`/`uio_oe` so no requester touches the pins directly. It sits between the user core and the top-level `tt_um_*` pin frame.

## Interface
- `NREQ`, default 2: number of requesters, 2..4.
- `LENW`, default 4: burst-length field width; a burst carries len+1 beats.
- `GAP`, default 1: turnaround cycles with `uio_oe`=0 before each burst; must be ≥1.

- `clk`  in  1: single clock for all state.
- `rst`  in  1: reset, synchronous and active-high.
- `req`  in  NREQ: per-requester request; held high for the whole burst.
- `len`  in  NREQ*LENW: per-requester beats-minus-one; sampled at grant.
- `wdata`  in  NREQ*8: per-requester beat data.
- `gnt`  out  NREQ: one-hot grant, registered.
- `beat_ack`  out  NREQ: the beat on `wdata[id]` is consumed this cycle.
- `done`  out  NREQ: 1-cycle pulse at the burst's end, whether complete or aborted.
- `busy`  out  1: the state is not IDLE.
- `uio_out`  out  8: pin data.
- `uio_oe`  out  8: pin output enable, either 8'h00 or 8'hFF.

## Operation
- States are IDLE, TURN and BURST.
- IDLE:
  - `gnt`=0, `uio_oe`=0, `uio_out`=0.
  - If any `req` is high, pick the winner round-robin, starting from the index after the last winner.
  - Latch the winner's `len` into the beat counter and its index into `id`.
  - Load the gap counter with GAP-1, set `gnt[id]`, and go to TURN.
- TURN:
  - `gnt[id]` stays high and `uio_oe` stays 0.
  - Decrement the gap counter; when it is 0, go to BURST.
- BURST:
  - `uio_oe`=8'hFF.
  - `uio_out`=`wdata[id]`, driven combinationally from the granted slice.
  - `beat_ack[id]`=1 each cycle; the requester presents the next beat on the following cycle.
  - The beat counter decrements per beat. On the beat where the counter is 0, assert `done[id]`, then go to IDLE: `gnt` and `uio_oe` drop on the next edge.
- Abort: if `req[id]` is low in TURN or BURST, then in that cycle:
  - `beat_ack`=0 and `uio_oe`=0, so no beat is counted;
  - `done[id]`=1;
  - go to IDLE next.
- Round-robin pointer:
  - It updates to `id` at grant time, so the next search starts at `id`+1, modulo NREQ.
  - After reset the pointer is NREQ-1, so requester 0 wins the first contention.
- Simultaneous requests are resolved only in IDLE. A `req` that rises during another burst waits; it is never lost while held.
- `len` changes after grant are ignored.
- Reset state:
  - `gnt`, `beat_ack`, `done`, `busy` = 0;
  - `uio_oe`=8'h00, `uio_out`=8'h00;
  - state IDLE, counters 0, pointer NREQ-1.
- `rst` mid-burst: the pins tri-state at the next edge. No `done` is emitted.

## Timing
- `req` sampled high in IDLE at edge E0:
  - `gnt`/`busy` are high from E0;
  - `uio_oe` is high from E0+GAP through E0+GAP+len+1;
  - `done` is in the last BURST cycle.
- Back-to-back bursts are separated by 1 IDLE cycle plus GAP TURN cycles, all with `uio_oe`=0. Minimum non-driving time is GAP+1 cycles.
- Peak throughput is 1 beat/cycle within a burst. There is no backpressure from the pins.
- `gnt` and `busy` are registered. `beat_ack`, `done`, `uio_out` and `uio_oe` are combinational from registered state plus `req[id]`/`wdata`.

## Structure
- Package `uio_arb_pkg`:
  - state enum (IDLE, TURN, BURST);
  - `OE_ON`=8'hFF and `OE_OFF`=8'h00;
  - max-NREQ constant and the `id` width function.
- Sub-module `rr_pick`: combinational round-robin picker. It takes the request vector and the pointer, and outputs a one-hot winner and its index.
- The top holds the FSM, gap counter, beat counter and output muxing.

## Test plan
- Reset: hold `rst`=1 with `req`=2'b11 → `uio_oe`=8'h00, `gnt`=0, `busy`=0 every cycle.
- Single burst, requester 1:
  - stimulus: GAP=1, `len[1]`=3, `wdata[1]` stepping 8'hA0..A3;
  - `gnt`=2'b10 from E0;
  - `uio_oe`=8'hFF for exactly 4 cycles starting E0+1;
  - `uio_out` = A0, A1, A2, A3;
  - `done[1]` on the A3 cycle.
- Contention:
  - `req`=2'b11 held, `len`=0 for both;
  - grants alternate 0,1,0,1;
  - every burst is preceded by ≥2 cycles of `uio_oe`=0.
- Abort: drop `req[0]` after 2 of 6 beats → 2 `beat_ack`, then `done[0]` with `uio_oe`=0 that cycle, then IDLE.
- Reset mid-burst: assert `rst` on beat 3 → `uio_oe`=0 from the next edge, no `done`. The next contention grants requester 0.
- GAP=3, NREQ=4, `req`=4'b1000 → `uio_oe` rises exactly 3 cycles after `gnt[3]`.

Source files
------------

// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pin-bank arbiter.
package uio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        BURST = 2'd2
    } arb_state_e;

    localparam logic [7:0] OE_ON    = 8'hFF;
    localparam logic [7:0] OE_OFF   = 8'h00;
    localparam int         MAX_NREQ = 4;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int width_for(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    // Width of a requester index.
    function automatic int id_width(input int nreq);
        return width_for(nreq);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the search starts one past the pointer.
module rr_pick
    import uio_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [IDW-1:0]  win_id,
    output logic            win_valid
);

    logic           found;
    logic [IDW-1:0] idx;

    // Walk the requesters in rotated order and keep the first one that is high.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        win_oh    = '0;
        win_id    = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found       = 1'b1;
                win_id      = idx;
                win_oh[idx] = 1'b1;
            end
        end
        win_valid = found;
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the 8-bit uio pin bank: grant, turnaround gap, then a
// length-tagged burst driven straight from the granted requester's data.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int LENW = 4,
    parameter int GAP  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] len,
    input  logic [NREQ*8-1:0]    wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      beat_ack,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic [7:0]           uio_out,
    output logic [7:0]           uio_oe
);

    localparam int IDW = id_width(NREQ);
    localparam int GW  = width_for(GAP);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [LENW-1:0] beat_q, beat_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [NREQ-1:0] gnt_q, gnt_d;

    logic [NREQ-1:0] pick_oh;
    logic [IDW-1:0]  pick_id;
    logic            pick_valid;

    logic [7:0]      wdata_arr [NREQ];
    logic [LENW-1:0] len_arr   [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign wdata_arr[g] = wdata[g*8 +: 8];
        assign len_arr[g]   = len[g*LENW +: LENW];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req       (req),
        .ptr       (ptr_q),
        .win_oh    (pick_oh),
        .win_id    (pick_id),
        .win_valid (pick_valid)
    );

    // State register: FSM, counters, granted index, pointer and grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= IDLE;
            id_q    <= '0;
            ptr_q   <= IDW'(NREQ - 1);
            beat_q  <= '0;
            gap_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            gnt_q   <= gnt_d;
        end
    end

    // Next-state logic and pin/handshake outputs; an absent req[id] aborts the burst.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        beat_d   = beat_q;
        gap_d    = gap_q;
        gnt_d    = gnt_q;
        beat_ack = '0;
        done     = '0;
        uio_oe   = OE_OFF;
        uio_out  = 8'h00;

        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_valid) begin
                    id_d    = pick_id;
                    ptr_d   = pick_id;
                    beat_d  = len_arr[pick_id];
                    gap_d   = GW'(GAP - 1);
                    gnt_d   = pick_oh;
                    state_d = TURN;
                end
            end
            TURN: begin
                if (!req[id_q]) begin
                    done[id_q] = 1'b1;
                    gnt_d      = '0;
                    state_d    = IDLE;
                end else if (gap_q == '0) begin
                    state_d = BURST;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            BURST: begin
                if (!req[id_q]) begin
                    done[id_q] = 1'b1;
                    gnt_d      = '0;
                    state_d    = IDLE;
                end else begin
                    uio_oe         = OE_ON;
                    uio_out        = wdata_arr[id_q];
                    beat_ack[id_q] = 1'b1;
                    if (beat_q == '0) begin
                        done[id_q] = 1'b1;
                        gnt_d      = '0;
                        state_d    = IDLE;
                    end else begin
                        beat_d = beat_q - LENW'(1);
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign gnt  = gnt_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for the uio arbiter: one default instance and one
// four-requester instance with a three-cycle turnaround gap.
module tb_uio_bus_arbiter;

    logic        clk;
    logic        rst;

    logic [1:0]  req;
    logic [7:0]  len;
    logic [15:0] wdata;
    logic [1:0]  gnt, beat_ack, done;
    logic        busy;
    logic [7:0]  uio_out, uio_oe;

    logic [3:0]  req4;
    logic [15:0] len4;
    logic [31:0] wdata4;
    logic [3:0]  gnt4, beat_ack4, done4;
    logic        busy4;
    logic [7:0]  uio_out4, uio_oe4;

    int checks;
    int errors;

    uio_bus_arbiter #(.NREQ(2), .LENW(4), .GAP(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .len      (len),
        .wdata    (wdata),
        .gnt      (gnt),
        .beat_ack (beat_ack),
        .done     (done),
        .busy     (busy),
        .uio_out  (uio_out),
        .uio_oe   (uio_oe)
    );

    uio_bus_arbiter #(.NREQ(4), .LENW(4), .GAP(3)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .req      (req4),
        .len      (len4),
        .wdata    (wdata4),
        .gnt      (gnt4),
        .beat_ack (beat_ack4),
        .done     (done4),
        .busy     (busy4),
        .uio_out  (uio_out4),
        .uio_oe   (uio_oe4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1 ns later.
    task automatic fall;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = 2'b11;
        len    = 8'h00;
        wdata  = 16'h0000;
        req4   = 4'b0000;
        len4   = 16'h0000;
        wdata4 = 32'h0000_0000;

        // Reset held with both requests up: nothing granted, pins tri-stated.
        for (int i = 0; i < 3; i++) begin
            fall(); #1;
            check("rst_oe",   uio_oe,  8'h00);
            check("rst_gnt",  gnt,     2'b00);
            check("rst_busy", busy,    1'b0);
            check("rst_out",  uio_out, 8'h00);
            check("rst_done", done,    2'b00);
        end
        req = 2'b00;
        fall();
        rst = 1'b0;
        fall(); #1;
        check("idle_busy", busy, 1'b0);

        // Single burst from requester 1, len=3, data A0..A3.
        req   = 2'b10;
        len   = 8'h30;
        wdata = 16'hA000;
        fall(); #1;
        check("single_turn_gnt",  gnt,    2'b10);
        check("single_turn_busy", busy,   1'b1);
        check("single_turn_oe",   uio_oe, 8'h00);
        for (int i = 0; i < 4; i++) begin
            fall(); #1;
            check("single_oe",   uio_oe,   8'hFF);
            check("single_out",  uio_out,  8'hA0 + 8'(i));
            check("single_ack",  beat_ack, 2'b10);
            check("single_done", done,     (i == 3) ? 2'b10 : 2'b00);
            check("single_gnt",  gnt,      2'b10);
            wdata = {8'hA1 + 8'(i), 8'h00};
        end
        fall();
        req = 2'b00;
        #1;
        check("single_end_oe",   uio_oe, 8'h00);
        check("single_end_gnt",  gnt,    2'b00);
        check("single_end_busy", busy,   1'b0);

        // Contention: both held with len=0, grants alternate starting at 0.
        req   = 2'b11;
        len   = 8'h00;
        wdata = 16'h5A3C;
        for (int b = 0; b < 4; b++) begin
            fall(); #1;
            check("cont_turn_gnt", gnt,    (b % 2 == 1) ? 2'b10 : 2'b01);
            check("cont_turn_oe",  uio_oe, 8'h00);
            fall(); #1;
            check("cont_oe",   uio_oe,  8'hFF);
            check("cont_out",  uio_out, (b % 2 == 1) ? 8'h5A : 8'h3C);
            check("cont_done", done,    (b % 2 == 1) ? 2'b10 : 2'b01);
            fall();
            if (b == 3) req = 2'b00;
            #1;
            check("cont_idle_oe",  uio_oe, 8'h00);
            check("cont_idle_gnt", gnt,    2'b00);
        end

        // Abort: requester 0 asks for 6 beats and drops req after 2.
        req   = 2'b01;
        len   = 8'h05;
        wdata = 16'h0011;
        fall(); #1;
        check("abort_turn_gnt", gnt, 2'b01);
        for (int i = 0; i < 2; i++) begin
            fall(); #1;
            check("abort_ack",  beat_ack, 2'b01);
            check("abort_oe",   uio_oe,   8'hFF);
            check("abort_done", done,     2'b00);
        end
        fall();
        req = 2'b00;
        #1;
        check("abort_cut_ack",  beat_ack, 2'b00);
        check("abort_cut_done", done,     2'b01);
        check("abort_cut_oe",   uio_oe,   8'h00);
        fall(); #1;
        check("abort_idle_busy", busy, 1'b0);
        check("abort_idle_done", done, 2'b00);

        // Reset on beat 3 of a requester-1 burst.
        req = 2'b10;
        len = 8'h50;
        fall(); #1;
        check("rstmid_gnt", gnt, 2'b10);
        for (int i = 0; i < 2; i++) begin
            fall(); #1;
            check("rstmid_oe", uio_oe, 8'hFF);
        end
        fall();
        rst = 1'b1;
        #1;
        check("rstmid_beat3_oe",   uio_oe, 8'hFF);
        check("rstmid_beat3_done", done,   2'b00);
        fall(); #1;
        check("rstmid_after_oe",   uio_oe, 8'h00);
        check("rstmid_after_done", done,   2'b00);
        check("rstmid_after_busy", busy,   1'b0);
        check("rstmid_after_gnt",  gnt,    2'b00);
        rst = 1'b0;
        req = 2'b11;
        fall(); #1;
        check("rstmid_next_gnt", gnt, 2'b01);
        req = 2'b00;
        #1;
        check("rstmid_turn_abort_done", done, 2'b01);
        fall(); #1;
        check("rstmid_final_busy", busy, 1'b0);

        // Four requesters, GAP=3: oe rises exactly three cycles after gnt[3].
        req4   = 4'b1000;
        len4   = 16'h1000;
        wdata4 = 32'hC500_0000;
        fall(); #1;
        check("g3_gnt", gnt4,    4'b1000);
        check("g3_oe0", uio_oe4, 8'h00);
        fall(); #1;
        check("g3_oe1", uio_oe4, 8'h00);
        fall(); #1;
        check("g3_oe2", uio_oe4, 8'h00);
        fall(); #1;
        check("g3_oe3",  uio_oe4,   8'hFF);
        check("g3_out",  uio_out4,  8'hC5);
        check("g3_ack",  beat_ack4, 4'b1000);
        check("g3_done0", done4,    4'b0000);
        fall(); #1;
        check("g3_oe4",   uio_oe4, 8'hFF);
        check("g3_done1", done4,   4'b1000);
        fall();
        req4 = 4'b0000;
        #1;
        check("g3_end_oe",   uio_oe4, 8'h00);
        check("g3_end_busy", busy4,   1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
